popcount_stream_acc: RTL and testbench

- Parametrised, clocked successor of the team's 3-input ones-counter (2-bit y1:y0 count).
- Accepts a stream of WIDTH-bit words over a valid/ready handshake. For each word it outputs that word's ones-count and a running total over a frame delimited by in_last.
- Sits between a word source and a statistics sink; one output beat per accepted input beat, registered output.

---
 rtl/popcount_stream_acc.sv | 161 ++++++++++++++++
 tb/tb_popcount_stream_acc.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/popcount_stream_acc.sv
// -----------------------------------------------------------------------------
// popcount_stream_acc
//
// Counts the ones in each WIDTH-bit word of a valid/ready stream and keeps a
// saturating running total over a frame delimited by in_last. One output beat
// is produced per accepted input beat, one cycle after acceptance, from a
// single output register stage (no skid buffer).
//
// Parameters:
//   WIDTH      bits per input word (>= 3)
//   ACC_WIDTH  width of the frame total accumulator (>= CW)
//   CW         (local) width of the per-word count, $clog2(WIDTH+1)
//
// Ports:
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready   input handshake; in_ready = !out_valid || out_ready
//   in_data, in_last      word to count, word closes the current frame
//   out_valid / out_ready output handshake
//   out_count             ones in the accepted word
//   out_total             saturating frame total including this word
//   out_first / out_last  beat opens / closes its frame
//   out_ovf               total saturated at some point in this frame
//   out_parity            XOR of the accepted word (only with POPCNT_PARITY_EN)
//
// Build option: define POPCNT_PARITY_EN to add the out_parity port.
// -----------------------------------------------------------------------------
module popcount_stream_acc #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 16,
  localparam int CW       = $clog2(WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CW-1:0]        out_count,
  output logic [ACC_WIDTH-1:0] out_total,
  output logic                 out_first,
  output logic                 out_last,
  output logic                 out_ovf
`ifdef POPCNT_PARITY_EN
  ,
  output logic                 out_parity
`endif
);

  typedef enum logic {
    IDLE  = 1'b0,
    FRAME = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic                   out_valid_q, out_valid_d;
  logic [CW-1:0]          out_count_q, out_count_d;
  logic [ACC_WIDTH-1:0]   out_total_q, out_total_d;
  logic                   out_first_q, out_first_d;
  logic                   out_last_q, out_last_d;
  logic                   out_ovf_q, out_ovf_d;
`ifdef POPCNT_PARITY_EN
  logic                   out_parity_q, out_parity_d;
`endif

  logic                   in_accept;
  logic                   frame_start;
  logic [CW-1:0]          word_count;
  logic [ACC_WIDTH-1:0]   acc_base;
  logic [ACC_WIDTH:0]     acc_sum;

  // The output register may be refilled in the same cycle it is drained.
  assign in_ready  = !out_valid_q || out_ready;
  assign in_accept = in_valid && in_ready;

  // The total register doubles as the accumulator: it always holds the
  // frame total as of the last accepted word.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    word_count = '0;
    for (int i = 0; i < WIDTH; i++) begin
      // NOTE: blocking assignments here build a chained sum; in always_ff
      // only non-blocking assignments are used.
      word_count = word_count + CW'(in_data[i]);
    end

    frame_start = (state_q == IDLE);
    acc_base    = frame_start ? '0 : out_total_q;
    // One extra bit catches the carry that signals saturation.
    acc_sum     = {1'b0, acc_base} + {{(ACC_WIDTH + 1 - CW){1'b0}}, word_count};
  end

  always_comb begin
    state_d      = state_q;
    out_valid_d  = out_valid_q;
    out_count_d  = out_count_q;
    out_total_d  = out_total_q;
    out_first_d  = out_first_q;
    out_last_d   = out_last_q;
    out_ovf_d    = out_ovf_q;
`ifdef POPCNT_PARITY_EN
    out_parity_d = out_parity_q;
`endif

    if (in_accept) begin
      out_valid_d  = 1'b1;
      out_count_d  = word_count;
      out_total_d  = acc_sum[ACC_WIDTH] ? '1 : acc_sum[ACC_WIDTH-1:0];
      // Sticky within a frame, cleared by the first beat of the next one.
      out_ovf_d    = (frame_start ? 1'b0 : out_ovf_q) | acc_sum[ACC_WIDTH];
      out_first_d  = frame_start;
      out_last_d   = in_last;
`ifdef POPCNT_PARITY_EN
      out_parity_d = ^in_data;
`endif
      state_d      = in_last ? IDLE : FRAME;
    end else if (out_valid_q && out_ready) begin
      // Drained with nothing new: only valid drops, data fields keep values.
      out_valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      out_valid_q  <= 1'b0;
      out_count_q  <= '0;
      out_total_q  <= '0;
      out_first_q  <= 1'b0;
      out_last_q   <= 1'b0;
      out_ovf_q    <= 1'b0;
`ifdef POPCNT_PARITY_EN
      out_parity_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      out_valid_q  <= out_valid_d;
      out_count_q  <= out_count_d;
      out_total_q  <= out_total_d;
      out_first_q  <= out_first_d;
      out_last_q   <= out_last_d;
      out_ovf_q    <= out_ovf_d;
`ifdef POPCNT_PARITY_EN
      out_parity_q <= out_parity_d;
`endif
    end
  end

  assign out_valid  = out_valid_q;
  assign out_count  = out_count_q;
  assign out_total  = out_total_q;
  assign out_first  = out_first_q;
  assign out_last   = out_last_q;
  assign out_ovf    = out_ovf_q;
`ifdef POPCNT_PARITY_EN
  assign out_parity = out_parity_q;
`endif

endmodule

// File: tb/tb_popcount_stream_acc.sv
// -----------------------------------------------------------------------------
// tb_popcount_stream_acc
//
// Three instances share one handshake: the main 8-bit/16-bit instance, a
// 3-bit instance for the legacy ones-counter values, and an 8-bit instance
// with a 4-bit accumulator for saturation. A frame-level model follows the
// main instance and is compared every cycle; directed literals pin all three.
// -----------------------------------------------------------------------------
module tb_popcount_stream_acc;

  localparam int W   = 8;
  localparam int AW  = 16;
  localparam int CWM = $clog2(W + 1);
  localparam longint ACC_MAX = (64'd1 << AW) - 1;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic [W-1:0]   in_data;
  logic           in_last;
  logic           out_ready;

  logic           in_ready, out_valid, out_first, out_last, out_ovf;
  logic [CWM-1:0] out_count;
  logic [AW-1:0]  out_total;

  logic           r3, v3, f3, l3, o3;
  logic [1:0]     c3;
  logic [15:0]    t3;

  logic           rs, vs, fs, ls, os;
  logic [3:0]     cs;
  logic [3:0]     ts;

`ifdef POPCNT_PARITY_EN
  logic out_parity, p3, ps;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  popcount_stream_acc #(.WIDTH(W), .ACC_WIDTH(AW)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_count(out_count), .out_total(out_total),
    .out_first(out_first), .out_last(out_last), .out_ovf(out_ovf)
`ifdef POPCNT_PARITY_EN
    , .out_parity(out_parity)
`endif
  );

  popcount_stream_acc #(.WIDTH(3), .ACC_WIDTH(16)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r3),
    .in_data(in_data[2:0]), .in_last(in_last), .out_valid(v3),
    .out_ready(out_ready), .out_count(c3), .out_total(t3),
    .out_first(f3), .out_last(l3), .out_ovf(o3)
`ifdef POPCNT_PARITY_EN
    , .out_parity(p3)
`endif
  );

  popcount_stream_acc #(.WIDTH(8), .ACC_WIDTH(4)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rs),
    .in_data(in_data), .in_last(in_last), .out_valid(vs),
    .out_ready(out_ready), .out_count(cs), .out_total(ts),
    .out_first(fs), .out_last(ls), .out_ovf(os)
`ifdef POPCNT_PARITY_EN
    , .out_parity(ps)
`endif
  );

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- frame-level model of the main instance ----------------
  logic        m_valid, m_first, m_last, m_ovf, m_parity, m_open;
  int          m_count;
  longint      m_sum;
  longint      m_total;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid = 0; m_first = 0; m_last = 0; m_ovf = 0; m_parity = 0;
      m_open = 0; m_count = 0; m_sum = 0; m_total = 0;
    end else if (in_valid && (!m_valid || out_ready)) begin
      m_count  = $countones(in_data);
      m_first  = !m_open;
      if (m_first) begin
        m_sum = 0;
        m_ovf = 0;
      end
      m_sum    = m_sum + m_count;
      m_total  = (m_sum > ACC_MAX) ? ACC_MAX : m_sum;
      m_ovf    = m_ovf || (m_sum > ACC_MAX);
      m_last   = in_last;
      m_parity = ^in_data;
      m_open   = !in_last;
      m_valid  = 1;
    end else if (m_valid && out_ready) begin
      m_valid = 0;
    end
  end

  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      check("cmp_in_ready",  in_ready,  !m_valid || out_ready);
      check("cmp_out_valid", out_valid, m_valid);
      check("cmp_count",     out_count, m_count);
      check("cmp_total",     out_total, m_total);
      check("cmp_first",     out_first, m_first);
      check("cmp_last",      out_last,  m_last);
      check("cmp_ovf",       out_ovf,   m_ovf);
`ifdef POPCNT_PARITY_EN
      check("cmp_parity",    out_parity, m_parity);
`endif
    end
  end

  // ---------------- stimulus helpers ----------------
  // Present a word, wait (bounded) until it is accepted, and return just
  // after the accepting edge so its outputs are visible.
  task automatic beat(input logic [W-1:0] data, input logic last);
    int budget = 20;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = data;
    in_last  = last;
    while (!in_ready && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) check("accept_timeout", in_ready, 1'b1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [2:0] leg_words [6] = '{3'b010, 3'b000, 3'b011, 3'b001, 3'b100, 3'b110};
  logic [1:0] leg_count [6] = '{2'd1, 2'd0, 2'd2, 2'd1, 2'd1, 2'd2};

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;

    // Reset
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_total", out_total, 0);
    check("rst_out_ovf",   out_ovf,   0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_in_ready",  in_ready,  1);
    check("rst_valid_idle", out_valid, 0);

    // Legacy 3-bit single-word frames
    foreach (leg_words[i]) begin
      beat({5'b0, leg_words[i]}, 1'b1);
      check("leg_count", c3, leg_count[i]);
      check("leg_first", f3, 1);
      check("leg_last",  l3, 1);
      check("leg_total", t3, 16'(leg_count[i]));
    end
    beat(8'h07, 1'b1);
    check("leg_all_ones", c3, 3);
    idle(1);
    check("leg_drain_valid", v3, 0);

    // 8-bit frame
    beat(8'hFF, 1'b0);
    check("frm_count0", out_count, 8);  check("frm_total0", out_total, 8);
    check("frm_first0", out_first, 1);  check("frm_last0",  out_last, 0);
    beat(8'h0F, 1'b0);
    check("frm_count1", out_count, 4);  check("frm_total1", out_total, 12);
    check("frm_first1", out_first, 0);  check("frm_last1",  out_last, 0);
    beat(8'h01, 1'b1);
    check("frm_count2", out_count, 1);  check("frm_total2", out_total, 13);
    check("frm_first2", out_first, 0);  check("frm_last2",  out_last, 1);
    beat(8'h03, 1'b1);
    check("frm_next_total", out_total, 2);
    check("frm_next_first", out_first, 1);
    beat(8'h00, 1'b1);
    check("frm_zero_count", out_count, 0);

    // Saturation on the 4-bit accumulator instance
    beat(8'hFF, 1'b0);
    check("sat_total0", ts, 8);  check("sat_ovf0", os, 0);
    beat(8'hFF, 1'b0);
    check("sat_total1", ts, 15); check("sat_ovf1", os, 1);
    beat(8'h00, 1'b1);
    check("sat_total2", ts, 15); check("sat_ovf2", os, 1);
    beat(8'h01, 1'b1);
    check("sat_next_total", ts, 1); check("sat_next_ovf", os, 0);

    // Backpressure: hold the sink for 3 cycles with a second word waiting
    beat(8'hAA, 1'b0);
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h81;
    in_last   = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      check("bp_hold_count", out_count, 4);
      check("bp_hold_total", out_total, 4);
      check("bp_in_ready",   in_ready,  0);
      check("bp_valid",      out_valid, 1);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_next_count", out_count, 2);
    check("bp_next_total", out_total, 6);
    check("bp_next_last",  out_last,  1);
    idle(1);
    check("bp_drained", out_valid, 0);
    check("bp_keep_total", out_total, 6);

    // Saturation of the 16-bit accumulator: 8192 x 8 = 65536 > 65535
    for (int i = 0; i < 8191; i++) beat(8'hFF, 1'b0);
    check("big_total_pre", out_total, 16'hFFF8);
    check("big_ovf_pre",   out_ovf,   0);
    beat(8'hFF, 1'b0);
    check("big_total_sat", out_total, 16'hFFFF);
    check("big_ovf_sat",   out_ovf,   1);
    beat(8'h00, 1'b1);
    check("big_ovf_sticky", out_ovf, 1);
    beat(8'h01, 1'b1);
    check("big_next_total", out_total, 1);
    check("big_next_ovf",   out_ovf,   0);

    // Reset in the middle of a frame
    beat(8'h0F, 1'b0);
    beat(8'h01, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_total", out_total, 0);
    @(negedge clk);
    rst_n = 1'b1;
    beat(8'h03, 1'b0);
    check("mid_first", out_first, 1);
    check("mid_total", out_total, 2);
    beat(8'h07, 1'b1);
    check("mid_total2", out_total, 5);
`ifdef POPCNT_PARITY_EN
    check("mid_parity", out_parity, 1);
`endif
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
